// File: rtl/adsr_envelope_if.sv
// adsr_envelope_if: audio/control bundle between the mixer side and the envelope.
// master drives lrck, gate, sustain_level, sig_in; slave (the envelope) drives the rest.
interface adsr_envelope_if;
  logic               lrck;
  logic               gate;
  logic        [15:0] sustain_level;
  logic signed [15:0] sig_in;
  logic signed [15:0] sig_out;
  logic        [15:0] env_level;
  logic        [2:0]  env_state;
  logic               active;

  modport master (
    output lrck, gate, sustain_level, sig_in,
    input  sig_out, env_level, env_state, active
  );

  modport slave (
    input  lrck, gate, sustain_level, sig_in,
    output sig_out, env_level, env_state, active
  );
endinterface

// File: rtl/adsr_envelope.sv
// adsr_envelope: ADSR amplitude envelope, one step per LRCK sample tick.
// Ports: clk, rst (sync, active high), bus (adsr_envelope_if.slave).
// bus in : lrck, gate, sustain_level[15:0], sig_in[15:0] signed
// bus out: sig_out[15:0] signed, env_level[15:0], env_state[2:0], active
// Build option: ADSR_EXP_RELEASE_EN selects exponential release.
module adsr_envelope #(
  parameter logic [15:0] ATTACK_STEP   = 16'd64,
  parameter logic [15:0] DECAY_STEP    = 16'd16,
`ifdef ADSR_EXP_RELEASE_EN
  parameter logic [3:0]  RELEASE_SHIFT = 4'd10
`else
  parameter logic [15:0] RELEASE_STEP  = 16'd8
`endif
) (
  input  logic           clk,
  input  logic           rst,
  adsr_envelope_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  logic               r_lrck_s1;
  logic               r_lrck_s2;
  logic               r_lrck_s3;
  logic               r_gate_q;
  logic signed [15:0] r_sample_q;
  logic signed [15:0] r_sig_out;
  state_t             r_state;
  logic        [15:0] r_env;

  logic               w_tick;
  logic               w_rise;
  state_t             w_state_nxt;
  state_t             w_stage;
  logic        [15:0] w_env_nxt;
  logic        [15:0] w_rel_dec;
  logic signed [32:0] w_prod;

  assign w_tick = r_lrck_s2 & ~r_lrck_s3;
  assign w_rise = bus.gate & ~r_gate_q;

  // env is unsigned, so widen with a zero MSB before the signed multiply
  assign w_prod = r_sample_q * $signed({1'b0, r_env});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lrck_s1  <= 1'b0;
      r_lrck_s2  <= 1'b0;
      r_lrck_s3  <= 1'b0;
      r_gate_q   <= 1'b0;
      r_sample_q <= '0;
      r_sig_out  <= '0;
    end else begin
      r_lrck_s1 <= bus.lrck;
      r_lrck_s2 <= r_lrck_s1;
      r_lrck_s3 <= r_lrck_s2;
      if (w_tick) begin
        r_gate_q   <= bus.gate;
        r_sample_q <= bus.sig_in;
      end
      // inputs only move on tick edges, so this holds between ticks
      r_sig_out <= 16'(w_prod >>> 16);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_env   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_env   <= w_env_nxt;
    end
  end

  always_comb begin
    w_rel_dec = '0;
`ifdef ADSR_EXP_RELEASE_EN
    w_rel_dec = r_env >> RELEASE_SHIFT;
    if (w_rel_dec == 16'd0) w_rel_dec = 16'd1;
`else
    w_rel_dec = RELEASE_STEP;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    w_stage     = r_state;
    if (w_tick) begin
      if (!bus.gate &&
          (r_state == S_ATTACK ||
           r_state == S_DECAY  ||
           r_state == S_SUSTAIN)) begin
        w_state_nxt = S_RELEASE;
      end else begin
        // a rise restarts attack from the current level, same tick
        w_stage = w_rise ? S_ATTACK : r_state;
        case (w_stage)
          S_IDLE: begin
            w_env_nxt = '0;
          end
          S_ATTACK: begin
            if (r_env > 16'hFFFF - ATTACK_STEP) begin
              w_env_nxt   = 16'hFFFF;
              w_state_nxt = S_DECAY;
            end else begin
              w_env_nxt   = r_env + ATTACK_STEP;
              w_state_nxt = S_ATTACK;
            end
          end
          S_DECAY: begin
            if ({1'b0, r_env} <=
                {1'b0, bus.sustain_level} + {1'b0, DECAY_STEP}) begin
              w_env_nxt   = bus.sustain_level;
              w_state_nxt = S_SUSTAIN;
            end else begin
              w_env_nxt = r_env - DECAY_STEP;
            end
          end
          S_SUSTAIN: begin
            w_env_nxt = bus.sustain_level;
          end
          S_RELEASE: begin
            if (r_env <= w_rel_dec) begin
              w_env_nxt   = '0;
              w_state_nxt = S_IDLE;
            end else begin
              w_env_nxt = r_env - w_rel_dec;
            end
          end
          default: begin
            w_env_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.sig_out   = r_sig_out;
  assign bus.env_level = r_env;
  assign bus.env_state = r_state;
  assign bus.active    = (r_state != S_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// tb_adsr_envelope: scoreboard bench for adsr_envelope.
// Stimulus queues expected results per lrck tick; a monitor checks them.
module tb_adsr_envelope;

  logic clk;
  logic rst;

  adsr_envelope_if bus ();

  adsr_envelope dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit chk;
    int env;
    int st;
    int sig;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int rel(input int e);
    int d;
`ifdef ADSR_EXP_RELEASE_EN
    d = e >> 10;
    if (d < 1) d = 1;
`else
    d = 8;
`endif
    return (e <= d) ? 0 : e - d;
  endfunction

  // one lrck period = 6 clk; env settles 3 clk after the rise, sig_out 4
  task automatic tick(input bit g, input int sin, input bit c,
                      input int env, input int st, input int sig);
    exp_t x;
    x.chk = c;
    x.env = env;
    x.st  = st;
    x.sig = sig;
    q.push_back(x);
    bus.gate   = g;
    bus.sig_in = 16'(sin);
    bus.lrck   = 1'b1;
    repeat (3) @(negedge clk);
    bus.lrck = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge bus.lrck);
      repeat (4) @(posedge clk);
      #1;
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL queue: tick with no expected entry");
      end else begin
        e = q.pop_front();
        if (e.chk) begin
          chk("env_level", int'(bus.env_level), e.env);
          chk("env_state", int'(bus.env_state), e.st);
          chk("active", int'(bus.active), int'(e.st != 0));
          chk("sig_out", int'(bus.sig_out), e.sig);
        end
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_env"}, int'(bus.env_level), 0);
    chk({tag, "_state"}, int'(bus.env_state), 0);
    chk({tag, "_active"}, int'(bus.active), 0);
    chk({tag, "_sig"}, int'(bus.sig_out), 0);
  endtask

  initial begin
    int ev;
    int r;
    bus.lrck          = 1'b0;
    bus.gate          = 1'b0;
    bus.sustain_level = 16'd32768;
    bus.sig_in        = '0;
    rst               = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset("rst0");

    for (int n = 1; n <= 1024; n++)
      tick(1, (n == 1024) ? 1000 : 0, (n == 1 || n == 512 || n >= 1023),
           (n == 1024) ? 65535 : 64 * n, (n == 1024) ? 2 : 1,
           (n == 1024) ? 999 : 0);

    for (int n = 1; n <= 2048; n++)
      tick(1, 0, (n == 1 || n == 1024 || n >= 2047),
           (n == 2048) ? 32768 : 65535 - 16 * n, (n == 2048) ? 3 : 2, 0);

    tick(1, 1000, 1, 32768, 3, 500);
    tick(1, -1001, 1, 32768, 3, -501);
    bus.sustain_level = 16'd40000;
    tick(1, -32768, 1, 40000, 3, -20000);
    bus.sustain_level = 16'd10000;
    tick(1, 0, 1, 10000, 3, 0);

    tick(0, 0, 1, 10000, 4, 0);
    tick(1, 0, 1, 10064, 1, 0);
    tick(1, 0, 1, 10128, 1, 0);

    bus.sustain_level = 16'd65535;
    for (int n = 1; n <= 865; n++)
      tick(1, 0, (n == 865), 10128 + 64 * n, 1, 0);
    tick(1, 0, 1, 65535, 2, 0);
    tick(1, 0, 1, 65535, 3, 0);
    bus.sustain_level = 16'd32768;
    tick(1, 0, 1, 32768, 3, 0);

    tick(0, 0, 1, 32768, 4, 0);
    ev = 32768;
    while (ev != 0) begin
      ev = rel(ev);
      tick(0, 0, 1, ev, (ev == 0) ? 0 : 4, 0);
    end
    tick(0, 1234, 1, 0, 0, 0);

    for (int n = 1; n <= 1023; n++)
      tick(1, 0, (n == 1 || n == 1023), 64 * n, 1, 0);
    tick(0, 0, 1, 65472, 4, 0);
    r = rel(65472);
    tick(0, 0, 1, r, 4, 0);
    tick(1, 0, 1, r + 64, 1, 0);
    tick(1, 0, 1, 65535, 2, 0);
    bus.sustain_level = 16'd65535;
    tick(1, 0, 1, 65535, 3, 0);
    bus.sustain_level = 16'd40000;
    tick(1, 1000, 1, 40000, 3, 610);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("rst_mid");

    tick(1, 0, 1, 64, 1, 0);

    repeat (20) @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
